nf_uart_tx_slave: RTL and testbench
===================================

# nf_uart_tx_slave

Memory-mapped UART transmitter that sits on one slave port of the data-memory router and responds to CPU load/store commands. The CPU programs a baud divider, enables the transmitter, and writes a byte. The block serialises that byte as an 8N1 frame on `uart_tx` and reports busy and done status through a readable control register.

## Interface
- `Div_rst`, 16'd868: reset value of the baud divider (clock cycles per bit).
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `addr_dm_s`  in  32  slave address; only `addr_dm_s[3:2]` is decoded.
- `we_dm_s`  in  1  write enable; already qualified by the router's slave select.
- `wd_dm_s`  in  32  write data.
- `rd_dm_s`  out  32  read data; combinational from `addr_dm_s` and register state, zero wait states.
- `uart_tx`  out  1  serial output; idle high.

## Operation
Register map, by `addr_dm_s[3:2]`:
- 0 CR:
  - bit0 `tx_en` (RW).
  - bit1 `busy` (RO).
  - bit2 `done` (sticky; writing 1 clears it, writing 0 leaves it unchanged).
  - Other bits read 0.
- 1 TX:
  - Write `[7:0]` = byte to send; read returns the last accepted byte, zero-extended.
- 2 DR:
  - bits `[15:0]` = baud divider (RW); upper bits read 0.
- 3 reserved: reads 0, writes ignored.

Start rule:
- A TX write is accepted only when `tx_en`=1 and `busy`=0.
- Otherwise the write is dropped: TX register unchanged, no frame.

On acceptance:
- Latch the byte into the shift register.
- Latch the effective divider, `max(DR,1)`, into the bit-period reload.
- Enter START.

Writing DR while busy updates the register immediately but affects only the next frame. Clearing `tx_en` mid-frame does not abort the frame; it only blocks new starts.

FSM states:
- IDLE: `uart_tx`=1, `busy`=0.
- START: `uart_tx`=0 for one bit period, then DATA.
- DATA: 8 bits, LSB first, one bit period each.
  - A 3-bit counter tracks the bit index.
  - After bit 7 the FSM moves to STOP.
- STOP: `uart_tx`=1 for one bit period, then IDLE.
  - `done` is set on the same edge the FSM enters IDLE.

Bit timer and counters:
- The bit timer is a 16-bit down-counter.
  - Loaded with divider−1 on entry to each bit.
  - The bit ends on the edge where the counter is 0.
- `busy` equals (state != IDLE).

Done-flag conflicts:
- A set and a write-1-clear of `done` on the same edge: set wins.
- A TX write on the same edge the FSM returns to IDLE is dropped, because `busy` is still 1 at that edge.

Reset values:
- `tx_en`=0, `busy`=0, `done`=0, TX=0, DR=`Div_rst`.
- State IDLE, `uart_tx`=1, timer=0.
- `rd_dm_s` = 0 for address 0 after reset.
- Reset asserted mid-frame forces `uart_tx`=1 and IDLE immediately (asynchronously); the partial frame is lost.

## Timing
- A write takes effect on the rising edge where `we_dm_s`=1.
  - Reads of the written register show the new value in the following cycle.
- An accepted TX write at edge k:
  - `busy`=1 and `uart_tx`=0 are visible after edge k.
  - Start bit: cycles k..k+D−1 (D = effective divider).
  - Data bit i: cycles k+(1+i)·D .. k+(2+i)·D−1.
  - Stop bit ends at edge k+10·D, where `busy`→0 and `done`→1.
- Frame length is exactly 10·D cycles.
  - Back-to-back frames require a new TX write no earlier than edge k+10·D+1, giving at least 1 idle-high cycle.
- `uart_tx` is a registered output, glitch-free.
- `rd_dm_s` has no pipeline; it is valid in the same cycle as `addr_dm_s`.

## Test plan
- Reset, then read addresses 0/4/8/C:
  - Required: 0x0, 0x0, 0x364 (default 868), 0x0.
  - `uart_tx`=1 throughout.
- DR=4, CR=1, TX=0xA5:
  - `uart_tx` sequence per 4-cycle bit must be 0,1,0,1,0,0,1,0,1,1.
  - `busy` high for exactly 40 cycles.
  - CR then reads 0x5.
- While busy, write TX=0x3C and DR=2:
  - The frame continues 0xA5 at 4 cycles/bit.
  - TX reads 0xA5.
  - The next TX write produces a frame at 2 cycles/bit.
- `tx_en`=0, write TX=0x55:
  - No frame; `busy` stays 0; TX reads the previous value.
- DR=0, `tx_en`=1, TX=0xFF:
  - Frame runs at 1 cycle/bit, 10 cycles total.
  - Write CR=0x5: `done` clears, `tx_en` stays 1.
- DR=8, start TX=0x81, assert `resetn`=0 at cycle 20:
  - `uart_tx`=1 and `busy`=0 immediately.
  - After release, DR reads 868.
  - No further activity on `uart_tx`.

Source files
------------

// File: rtl/nf_uart_tx_slave.sv
// ---------------------------------------------------------------------------
// nf_uart_tx_slave
//
// Memory-mapped 8N1 UART transmitter on a data-memory router slave port.
// The CPU programs a baud divider (clock cycles per bit), enables the
// transmitter and writes a byte; the block then shifts the frame out on
// uart_tx and reports busy/done through the control register.
//
// Register map (addr_dm_s[3:2]):
//   0 CR : bit0 tx_en (RW), bit1 busy (RO), bit2 done (sticky, W1C)
//   1 TX : write [7:0] starts a frame; read returns last accepted byte
//   2 DR : [15:0] baud divider (RW)
//   3    : reserved, reads 0, writes ignored
//
// Ports:
//   clk        clock, rising edge
//   resetn     asynchronous active-low reset
//   addr_dm_s  slave address (only [3:2] decoded)
//   we_dm_s    write enable, already qualified by slave select
//   wd_dm_s    write data
//   rd_dm_s    combinational read data, zero wait states
//   uart_tx    registered serial output, idle high
// ---------------------------------------------------------------------------
module nf_uart_tx_slave #(
    parameter logic [15:0] Div_rst = 16'd868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] addr_dm_s,
    input  logic        we_dm_s,
    input  logic [31:0] wd_dm_s,
    output logic [31:0] rd_dm_s,
    output logic        uart_tx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        tx_en;
    logic        done;
    logic [7:0]  tx_reg;
    logic [15:0] dr;

    logic [7:0]  shreg;
    logic [7:0]  shreg_next;
    logic [15:0] bit_len;
    logic [15:0] timer;
    logic [2:0]  bit_idx;
    logic        uart_tx_next;

    logic        busy;
    logic        bit_end;
    logic        wr_cr;
    logic        wr_tx;
    logic        wr_dr;
    logic        accept;
    logic        done_set;
    logic [15:0] eff_div;

    // Address bits outside [3:2] and the upper write-data half carry no meaning here.
    logic        unused_bits;
    assign unused_bits = ^{addr_dm_s[31:4], addr_dm_s[1:0], wd_dm_s[31:16]};

    assign busy     = (state != ST_IDLE);
    assign bit_end  = busy && (timer == 16'd0);
    assign wr_cr    = we_dm_s && (addr_dm_s[3:2] == 2'd0);
    assign wr_tx    = we_dm_s && (addr_dm_s[3:2] == 2'd1);
    assign wr_dr    = we_dm_s && (addr_dm_s[3:2] == 2'd2);
    // A TX write on the very edge the frame finishes still sees busy=1 and is dropped.
    assign accept   = wr_tx && tx_en && !busy;
    assign done_set = (state == ST_STOP) && bit_end;
    // A divider of 0 would stall the timer; treat it as 1 cycle per bit.
    assign eff_div  = (dr == 16'd0) ? 16'd1 : dr;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept)                          state_next = ST_START;
            ST_START: if (bit_end)                         state_next = ST_DATA;
            ST_DATA:  if (bit_end && (bit_idx == 3'd7))    state_next = ST_STOP;
            ST_STOP:  if (bit_end)                         state_next = ST_IDLE;
            default:                                       state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic. uart_tx is computed from the upcoming state so the
    // registered pin changes on the same edge as the state.
    // -----------------------------------------------------------------------
    always_comb begin
        uart_tx_next = 1'b1;
        case (state_next)
            ST_IDLE:  uart_tx_next = 1'b1;
            ST_START: uart_tx_next = 1'b0;
            ST_DATA:  uart_tx_next = shreg_next[0];
            ST_STOP:  uart_tx_next = 1'b1;
            default:  uart_tx_next = 1'b1;
        endcase
    end

    // Shift register: load on start, shift right (LSB first) at each data-bit end.
    always_comb begin
        shreg_next = shreg;
        if (accept) begin
            shreg_next = wd_dm_s[7:0];
        end else if ((state == ST_DATA) && bit_end) begin
            shreg_next = {1'b0, shreg[7:1]};
        end
    end

    // Bit timer, bit counter, shifter and the output flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer   <= 16'd0;
            bit_len <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            uart_tx <= 1'b1;
        end else begin
            shreg   <= shreg_next;
            uart_tx <= uart_tx_next;
            if (accept) begin
                bit_len <= eff_div;
                timer   <= eff_div - 16'd1;
                bit_idx <= 3'd0;
            end else if (bit_end) begin
                timer <= (state_next == ST_IDLE) ? 16'd0 : (bit_len - 16'd1);
                if (state == ST_DATA) begin
                    bit_idx <= bit_idx + 3'd1;
                end
            end else if (busy) begin
                timer <= timer - 16'd1;
            end
        end
    end

    // Software-visible registers. DR may change mid-frame; the running frame
    // keeps using bit_len captured at start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_en  <= 1'b0;
            done   <= 1'b0;
            tx_reg <= 8'd0;
            dr     <= Div_rst;
        end else begin
            if (wr_cr) begin
                tx_en <= wd_dm_s[0];
            end
            // Hardware set beats a simultaneous write-1-clear.
            if (done_set) begin
                done <= 1'b1;
            end else if (wr_cr && wd_dm_s[2]) begin
                done <= 1'b0;
            end
            if (accept) begin
                tx_reg <= wd_dm_s[7:0];
            end
            if (wr_dr) begin
                dr <= wd_dm_s[15:0];
            end
        end
    end

    // Read mux, purely combinational.
    always_comb begin
        rd_dm_s = 32'd0;
        case (addr_dm_s[3:2])
            2'd0:    rd_dm_s = {29'd0, done, busy, tx_en};
            2'd1:    rd_dm_s = {24'd0, tx_reg};
            2'd2:    rd_dm_s = {16'd0, dr};
            default: rd_dm_s = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_nf_uart_tx_slave.sv
// ---------------------------------------------------------------------------
// tb_nf_uart_tx_slave
//
// Self-checking bench for nf_uart_tx_slave: a register-access vector table
// followed by hand-written frame sequences (timing, mid-frame writes,
// disabled transmitter, divider 0, done set/clear collision, mid-frame reset).
// ---------------------------------------------------------------------------
module tb_nf_uart_tx_slave;

    logic        clk;
    logic        resetn;
    logic [31:0] addr_dm_s;
    logic        we_dm_s;
    logic [31:0] wd_dm_s;
    logic [31:0] rd_dm_s;
    logic        uart_tx;

    int tests;
    int fails;

    nf_uart_tx_slave #(.Div_rst(16'd868)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .addr_dm_s (addr_dm_s),
        .we_dm_s   (we_dm_s),
        .wd_dm_s   (wd_dm_s),
        .rd_dm_s   (rd_dm_s),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_dm_s = a;
        wd_dm_s   = d;
        we_dm_s   = 1'b1;
        @(negedge clk);
        we_dm_s   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        we_dm_s   = 1'b0;
        addr_dm_s = a;
        #1;
        d = rd_dm_s;
    endtask

    // Start a frame with byte b at divider d and check every cycle of it.
    // Up to two writes may be injected on the cycles before edges j1+1 / j2+1
    // (index counted from the accepting edge); -1 disables an injection.
    task automatic run_frame(input logic [7:0] b, input int d,
                             input int j1, input logic [31:0] a1, input logic [31:0] d1,
                             input int j2, input logic [31:0] a2, input logic [31:0] d2,
                             input string nm);
        int   err;
        int   bi;
        logic e;
        err = 0;
        @(negedge clk);
        addr_dm_s = 32'h4;
        wd_dm_s   = {24'd0, b};
        we_dm_s   = 1'b1;
        @(posedge clk);
        #1;
        we_dm_s   = 1'b0;
        addr_dm_s = 32'h0;
        for (int i = 0; i < 10 * d; i++) begin
            #1;
            bi = i / d;
            if (bi == 0)      e = 1'b0;
            else if (bi == 9) e = 1'b1;
            else              e = b[bi-1];
            if (uart_tx !== e) err++;
            if (!we_dm_s && addr_dm_s == 32'h0 && rd_dm_s[1] !== 1'b1) err++;
            we_dm_s   = 1'b0;
            addr_dm_s = 32'h0;
            if (i == j1) begin
                addr_dm_s = a1; wd_dm_s = d1; we_dm_s = 1'b1;
            end else if (i == j2) begin
                addr_dm_s = a2; wd_dm_s = d2; we_dm_s = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        we_dm_s   = 1'b0;
        addr_dm_s = 32'h0;
        #1;
        chk({nm, "_bits_busy_err"}, err, 0);
        chk({nm, "_end_tx"}, {31'd0, uart_tx}, 32'd1);
        chk({nm, "_end_busy"}, {31'd0, rd_dm_s[1]}, 32'd0);
        chk({nm, "_end_done"}, {31'd0, rd_dm_s[2]}, 32'd1);
    endtask

    vec_t        vecs[12];
    logic [31:0] r;
    int          err;

    initial begin
        vecs[0]  = '{1'b0, 32'h0,        32'h0,        32'h0,   "rst_cr"};
        vecs[1]  = '{1'b0, 32'h4,        32'h0,        32'h0,   "rst_tx"};
        vecs[2]  = '{1'b0, 32'h8,        32'h0,        32'h364, "rst_dr"};
        vecs[3]  = '{1'b0, 32'hC,        32'h0,        32'h0,   "rst_rsv"};
        vecs[4]  = '{1'b1, 32'h8,        32'h4,        32'h4,   "dr_4"};
        vecs[5]  = '{1'b1, 32'hC,        32'hFFFFFFFF, 32'h0,   "rsv_wr"};
        vecs[6]  = '{1'b1, 32'h0,        32'hFFFFFFFF, 32'h1,   "cr_all1"};
        vecs[7]  = '{1'b1, 32'h0,        32'h0,        32'h0,   "cr_0"};
        vecs[8]  = '{1'b1, 32'h8,        32'hFFFF1234, 32'h1234,"dr_trunc"};
        vecs[9]  = '{1'b0, 32'h1000_0008,32'h0,        32'h1234,"dr_alias"};
        vecs[10] = '{1'b1, 32'h8,        32'h4,        32'h4,   "dr_4b"};
        vecs[11] = '{1'b1, 32'h0,        32'h1,        32'h1,   "cr_en"};

        tests = 0;
        fails = 0;
        resetn    = 1'b0;
        addr_dm_s = 32'h0;
        we_dm_s   = 1'b0;
        wd_dm_s   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // Register access table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wd);
            rd(vecs[i].addr, r);
            chk(vecs[i].name, r, vecs[i].exp_rd);
        end
        chk("idle_uart_tx", {31'd0, uart_tx}, 32'd1);

        // Frame 0xA5 at 4 cycles/bit; TX=0x3C and DR=2 written while busy
        run_frame(8'hA5, 4, 8, 32'h4, 32'h3C, 9, 32'h8, 32'h2, "a5");
        rd(32'h0, r); chk("a5_cr", r, 32'h5);
        rd(32'h4, r); chk("a5_tx", r, 32'hA5);
        rd(32'h8, r); chk("a5_dr", r, 32'h2);

        // Frame 0x3C at 2 cycles/bit; TX write on the returning edge is dropped
        run_frame(8'h3C, 2, 19, 32'h4, 32'h99, -1, 32'h0, 32'h0, "3c");
        rd(32'h4, r); chk("3c_tx", r, 32'h3C);

        // Transmitter disabled: write dropped
        wr(32'h0, 32'h0);
        rd(32'h0, r); chk("dis_cr", r, 32'h4);
        wr(32'h4, 32'h55);
        err = 0;
        for (int i = 0; i < 20; i++) begin
            rd(32'h0, r);
            if (r[1] !== 1'b0 || uart_tx !== 1'b1) err++;
        end
        chk("dis_no_frame", err, 0);
        rd(32'h4, r); chk("dis_tx", r, 32'h3C);

        // Divider 0 -> 1 cycle/bit; CR write-1-clear collides with done set
        wr(32'h8, 32'h0);
        wr(32'h0, 32'h5);
        rd(32'h0, r); chk("d0_cr_pre", r, 32'h1);
        run_frame(8'hFF, 1, 9, 32'h0, 32'h5, -1, 32'h0, 32'h0, "ff");
        rd(32'h0, r); chk("ff_set_wins", r, 32'h5);
        wr(32'h0, 32'h5);
        rd(32'h0, r); chk("ff_clr", r, 32'h1);

        // Mid-frame reset
        wr(32'h8, 32'h8);
        @(negedge clk);
        addr_dm_s = 32'h4;
        wd_dm_s   = 32'h81;
        we_dm_s   = 1'b1;
        @(posedge clk);
        #1;
        we_dm_s   = 1'b0;
        addr_dm_s = 32'h0;
        repeat (20) @(posedge clk);
        #2;
        chk("mid_tx_before", {31'd0, uart_tx}, 32'd0);
        chk("mid_busy_before", {31'd0, rd_dm_s[1]}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("mid_rst_cr", rd_dm_s, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        rd(32'h8, r); chk("mid_rst_dr", r, 32'h364);
        err = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) err++;
        end
        chk("mid_quiet", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
